// File: rtl/cdb_broadcaster_if.sv
// FU result ports, CDB lanes and FIFO occupancy of cdb_broadcaster.
// slave is the broadcaster side; master is the FU / CDB consumer side.
interface cdb_broadcaster_if #(
    parameter int NUM_FU    = 4,
    parameter int CDB_W     = 3,
    parameter int BUF_DEPTH = 8,
    parameter int ROBLEN    = 32,
    parameter int XLEN      = 32
);
    localparam int TAGW = $clog2(ROBLEN);
    localparam int CNTW = $clog2(BUF_DEPTH + 1);

    logic [NUM_FU-1:0]      fu_valid;
    logic [NUM_FU-1:0]      fu_ready;
    logic [NUM_FU*TAGW-1:0] fu_tag;
    logic [NUM_FU*XLEN-1:0] fu_value;
    logic [NUM_FU-1:0]      fu_take_branch;
    logic [NUM_FU*XLEN-1:0] fu_npc;

    logic [CDB_W-1:0]       cdb_valid;
    logic [CDB_W*TAGW-1:0]  cdb_tag;
    logic [CDB_W*XLEN-1:0]  cdb_value;
    logic [CDB_W-1:0]       cdb_take_branch;
    logic [CDB_W*XLEN-1:0]  cdb_npc;

    logic [CNTW-1:0]        buf_count;

    modport slave (
        input  fu_valid, fu_tag, fu_value, fu_take_branch, fu_npc,
        output fu_ready, cdb_valid, cdb_tag, cdb_value, cdb_take_branch, cdb_npc, buf_count
    );

    modport master (
        output fu_valid, fu_tag, fu_value, fu_take_branch, fu_npc,
        input  fu_ready, cdb_valid, cdb_tag, cdb_value, cdb_take_branch, cdb_npc, buf_count
    );
endinterface

// File: rtl/cdb_broadcaster.sv
// Collects FU results onto a CDB_W-lane common data bus with an age-ordered overflow FIFO.
// Optional CDB_STATS_EN adds stall_cycles and max_occupancy statistics outputs.
module cdb_broadcaster #(
    parameter int NUM_FU    = 4,
    parameter int CDB_W     = 3,
    parameter int BUF_DEPTH = 8,
    parameter int ROBLEN    = 32,
    parameter int XLEN      = 32
) (
    input  logic clock,
    input  logic reset,
    input  logic squash_flag,
    cdb_broadcaster_if.slave bus
`ifdef CDB_STATS_EN
    ,
    output logic [31:0]                      stall_cycles,
    output logic [$clog2(BUF_DEPTH+1)-1:0]   max_occupancy
`endif
);
    localparam int TAGW = $clog2(ROBLEN);
    localparam int CNTW = $clog2(BUF_DEPTH + 1);
    localparam int PTRW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

    typedef struct packed {
        logic [TAGW-1:0] tag;
        logic [XLEN-1:0] value;
        logic            take_branch;
        logic [XLEN-1:0] npc;
    } result_t;

    function automatic logic [PTRW-1:0] wrap(input logic [PTRW-1:0] base, input int off);
        return PTRW'((32'(base) + 32'(off)) % 32'(BUF_DEPTH));
    endfunction

    result_t          fifo_mem [BUF_DEPTH];
    logic [PTRW-1:0]  head_q, tail_q;
    logic [CNTW-1:0]  count_q;
    result_t          lane_q [CDB_W];
    logic [CDB_W-1:0] valid_q;

    result_t          fu_res [NUM_FU];
    logic [NUM_FU-1:0] ready, accept, push_en;
    logic [PTRW-1:0]  push_addr [NUM_FU];
    int               fu_pos [NUM_FU];
    int               pop_n, new_count, push_n;
    result_t          lane_d [CDB_W];
    logic [CDB_W-1:0] valid_d;

    // NOTE: every signal written here gets a value on every path, so no latch is inferred.
    always_comb begin
        int cnt, valid_seen, rank, total, spill_base;
        cnt        = 32'(count_q);
        valid_seen = 0;
        rank       = 0;
        for (int i = 0; i < NUM_FU; i++) begin
            fu_res[i].tag         = bus.fu_tag[i*TAGW +: TAGW];
            fu_res[i].value       = bus.fu_value[i*XLEN +: XLEN];
            fu_res[i].take_branch = bus.fu_take_branch[i];
            fu_res[i].npc         = bus.fu_npc[i*XLEN +: XLEN];
            // Lower-index valids reserve room first, so readiness is a priority prefix.
            ready[i]  = reset && !squash_flag && (cnt + valid_seen < BUF_DEPTH + CDB_W);
            accept[i] = bus.fu_valid[i] && ready[i];
            fu_pos[i] = cnt + rank;
            if (bus.fu_valid[i]) valid_seen++;
            if (accept[i]) rank++;
        end

        pop_n      = (cnt < CDB_W) ? cnt : CDB_W;
        total      = cnt + rank;
        new_count  = total - ((total < CDB_W) ? total : CDB_W);
        push_n     = new_count - (cnt - pop_n);
        spill_base = (cnt > CDB_W) ? cnt : CDB_W;

        for (int i = 0; i < NUM_FU; i++) begin
            push_en[i]   = accept[i] && (fu_pos[i] >= CDB_W);
            push_addr[i] = push_en[i] ? wrap(tail_q, fu_pos[i] - spill_base) : '0;
        end

        for (int k = 0; k < CDB_W; k++) begin
            valid_d[k] = 1'b0;
            lane_d[k]  = '0;
            if (k < pop_n) begin
                valid_d[k] = 1'b1;
                lane_d[k]  = fifo_mem[wrap(head_q, k)];
            end
            for (int i = 0; i < NUM_FU; i++) begin
                if (accept[i] && fu_pos[i] == k) begin
                    valid_d[k] = 1'b1;
                    lane_d[k]  = fu_res[i];
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every block sees pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset || squash_flag) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            for (int k = 0; k < CDB_W; k++) lane_q[k] <= '0;
        end else begin
            head_q  <= wrap(head_q, pop_n);
            tail_q  <= wrap(tail_q, push_n);
            count_q <= CNTW'(new_count);
            valid_q <= valid_d;
            for (int k = 0; k < CDB_W; k++) lane_q[k] <= lane_d[k];
        end
    end

    // NOTE: the storage array has no reset; head/tail/count alone decide which entries are live.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_FU; i++) begin
            if (push_en[i]) fifo_mem[push_addr[i]] <= fu_res[i];
        end
    end

    assign bus.fu_ready  = ready;
    assign bus.cdb_valid = valid_q;
    assign bus.buf_count = count_q;

    for (genvar k = 0; k < CDB_W; k++) begin : g_lane
        assign bus.cdb_tag[k*TAGW +: TAGW]   = lane_q[k].tag;
        assign bus.cdb_value[k*XLEN +: XLEN] = lane_q[k].value;
        assign bus.cdb_take_branch[k]        = lane_q[k].take_branch;
        assign bus.cdb_npc[k*XLEN +: XLEN]   = lane_q[k].npc;
    end

`ifdef CDB_STATS_EN
    logic stall_now;
    assign stall_now = |(bus.fu_valid & ~ready);

    // Statistics survive squash; only reset clears them.
    always_ff @(posedge clock) begin
        if (!reset) begin
            stall_cycles  <= '0;
            max_occupancy <= '0;
        end else begin
            if (stall_now && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
            if (count_q > max_occupancy) max_occupancy <= count_q;
        end
    end
`endif

    assert property (@(posedge clock) disable iff (!reset) count_q <= CNTW'(BUF_DEPTH));

endmodule

// File: tb/tb_cdb_broadcaster.sv
// Self-checking bench for cdb_broadcaster: an age-ordered queue of accepted results is the
// expected CDB stream; buffer occupancy and FU readiness are derived from that queue.
module tb_cdb_broadcaster;
    localparam int NUM_FU    = 4;
    localparam int CDB_W     = 3;
    localparam int BUF_DEPTH = 8;
    localparam int ROBLEN    = 32;
    localparam int XLEN      = 32;
    localparam int TAGW      = $clog2(ROBLEN);
    localparam int CNTW      = $clog2(BUF_DEPTH + 1);

    typedef struct packed {
        logic [TAGW-1:0] tag;
        logic [XLEN-1:0] value;
        logic            take_branch;
        logic [XLEN-1:0] npc;
    } result_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic squash_flag = 1'b0;

    cdb_broadcaster_if #(.NUM_FU(NUM_FU), .CDB_W(CDB_W), .BUF_DEPTH(BUF_DEPTH),
                         .ROBLEN(ROBLEN), .XLEN(XLEN)) bus ();

`ifdef CDB_STATS_EN
    logic [31:0]     stall_cycles;
    logic [CNTW-1:0] max_occupancy;
`endif

    cdb_broadcaster #(.NUM_FU(NUM_FU), .CDB_W(CDB_W), .BUF_DEPTH(BUF_DEPTH),
                      .ROBLEN(ROBLEN), .XLEN(XLEN)) dut (
        .clock       (clock),
        .reset       (reset),
        .squash_flag (squash_flag),
        .bus         (bus)
`ifdef CDB_STATS_EN
        ,
        .stall_cycles  (stall_cycles),
        .max_occupancy (max_occupancy)
`endif
    );

    always #5 clock = ~clock;

    result_t         exp_q[$];
    int              n_checks = 0;
    int              n_pass   = 0;
    logic [TAGW-1:0] next_tag = '0;

    task automatic set_fu(input int i, input result_t r);
        bus.fu_tag[i*TAGW +: TAGW]   = r.tag;
        bus.fu_value[i*XLEN +: XLEN] = r.value;
        bus.fu_take_branch[i]        = r.take_branch;
        bus.fu_npc[i*XLEN +: XLEN]   = r.npc;
    endtask

    function automatic result_t get_fu(input int i);
        result_t r;
        r.tag         = bus.fu_tag[i*TAGW +: TAGW];
        r.value       = bus.fu_value[i*XLEN +: XLEN];
        r.take_branch = bus.fu_take_branch[i];
        r.npc         = bus.fu_npc[i*XLEN +: XLEN];
        return r;
    endfunction

    function automatic result_t lane(input int k);
        result_t r;
        r.tag         = bus.cdb_tag[k*TAGW +: TAGW];
        r.value       = bus.cdb_value[k*XLEN +: XLEN];
        r.take_branch = bus.cdb_take_branch[k];
        r.npc         = bus.cdb_npc[k*XLEN +: XLEN];
        return r;
    endfunction

    task automatic fresh_fu(input int i);
        result_t r;
        r.tag         = next_tag;
        r.value       = $urandom;
        r.take_branch = 1'($urandom_range(0, 1));
        r.npc         = $urandom;
        next_tag      = next_tag + 1'b1;
        set_fu(i, r);
    endtask

    task automatic refill(input logic [NUM_FU-1:0] acc);
        for (int i = 0; i < NUM_FU; i++) if (acc[i]) fresh_fu(i);
    endtask

    // Scoreboard: pushes accepted results before the edge, pops them off the CDB after it.
    task automatic run_cycle(output logic [NUM_FU-1:0] acc);
        logic [NUM_FU-1:0] exp_ready;
        logic [CDB_W-1:0]  exp_valid;
        result_t           got, want;
        int                seen, nemit;
        bit                flush, by_squash;
        @(negedge clock);
        exp_ready = '0;
        seen      = 0;
        if (reset && !squash_flag) begin
            for (int i = 0; i < NUM_FU; i++) begin
                exp_ready[i] = (exp_q.size() + seen < BUF_DEPTH + CDB_W);
                if (bus.fu_valid[i]) seen++;
            end
        end
        n_checks++;
        if (bus.fu_ready !== exp_ready)
            $display("FAIL sb_fu_ready: got %b expected %b", bus.fu_ready, exp_ready);
        else n_pass++;
        acc = bus.fu_valid & exp_ready;
        for (int i = 0; i < NUM_FU; i++) if (acc[i]) exp_q.push_back(get_fu(i));
        flush     = !reset || squash_flag;
        by_squash = reset && squash_flag;
        @(posedge clock);
        #1;
        if (flush) begin
            exp_q.delete();
            nemit = 0;
        end else begin
            nemit = (exp_q.size() < CDB_W) ? exp_q.size() : CDB_W;
        end
        exp_valid = '0;
        for (int k = 0; k < nemit; k++) exp_valid[k] = 1'b1;
        n_checks++;
        if (bus.cdb_valid !== exp_valid)
            $display("FAIL sb_cdb_valid: got %b expected %b", bus.cdb_valid, exp_valid);
        else n_pass++;
        for (int k = 0; k < CDB_W; k++) begin
            got  = lane(k);
            want = (k < nemit) ? exp_q.pop_front() : '0;
            if (!by_squash || k < nemit) begin
                n_checks++;
                if (got !== want)
                    $display("FAIL sb_lane%0d: got tag=%0d val=%h tb=%b npc=%h expected tag=%0d val=%h tb=%b npc=%h",
                             k, got.tag, got.value, got.take_branch, got.npc,
                             want.tag, want.value, want.take_branch, want.npc);
                else n_pass++;
            end
        end
        n_checks++;
        if (bus.buf_count !== CNTW'(exp_q.size()))
            $display("FAIL sb_buf_count: got %0d expected %0d", bus.buf_count, exp_q.size());
        else n_pass++;
    endtask

    task automatic drain();
        logic [NUM_FU-1:0] acc;
        for (int n = 0; n < 16 && (bus.fu_valid != '0 || exp_q.size() != 0); n++) begin
            run_cycle(acc);
            bus.fu_valid = bus.fu_valid & ~acc;
        end
    endtask

    task automatic test_reset();
        logic [NUM_FU-1:0] acc;
        reset        = 1'b0;
        bus.fu_valid = '0;
        repeat (2) begin
            run_cycle(acc);
            n_checks++;
            if (bus.fu_ready !== 4'b0000)
                $display("FAIL reset_ready_low: got %b expected %b", bus.fu_ready, 4'b0000);
            else n_pass++;
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (bus.fu_ready !== 4'b1111)
            $display("FAIL reset_ready_release: got %b expected %b", bus.fu_ready, 4'b1111);
        else n_pass++;
        run_cycle(acc);
        n_checks++;
        if (bus.cdb_valid !== 3'b000 || bus.buf_count !== 4'd0)
            $display("FAIL reset_state: got valid=%b count=%0d expected valid=000 count=0",
                     bus.cdb_valid, bus.buf_count);
        else n_pass++;
    endtask

    task automatic test_single();
        logic [NUM_FU-1:0] acc;
        result_t r, got;
        r.tag = 5'd5; r.value = 32'h1234; r.take_branch = 1'b1; r.npc = 32'h40;
        set_fu(0, r);
        bus.fu_valid = 4'b0001;
        run_cycle(acc);
        got = lane(0);
        n_checks++;
        if (bus.cdb_valid !== 3'b001 || got !== r || bus.buf_count !== 4'd0)
            $display("FAIL single: got valid=%b tag=%0d val=%h tb=%b npc=%h count=%0d expected valid=001 tag=5 val=1234 tb=1 npc=40 count=0",
                     bus.cdb_valid, got.tag, got.value, got.take_branch, got.npc, bus.buf_count);
        else n_pass++;
        bus.fu_valid = '0;
        run_cycle(acc);
    endtask

    task automatic test_burst();
        logic [NUM_FU-1:0] acc;
        result_t r;
        for (int i = 0; i < NUM_FU; i++) begin
            r.tag = TAGW'(i + 1); r.value = 32'h100 + i; r.take_branch = 1'b0; r.npc = 32'h200 + 4 * i;
            set_fu(i, r);
        end
        bus.fu_valid = 4'b1111;
        run_cycle(acc);
        n_checks++;
        if (bus.cdb_valid !== 3'b111 || {lane(2).tag, lane(1).tag, lane(0).tag} !== {5'd3, 5'd2, 5'd1}
            || bus.buf_count !== 4'd1)
            $display("FAIL burst_first: got valid=%b tags=%0d,%0d,%0d count=%0d expected valid=111 tags=1,2,3 count=1",
                     bus.cdb_valid, lane(0).tag, lane(1).tag, lane(2).tag, bus.buf_count);
        else n_pass++;
        bus.fu_valid = '0;
        run_cycle(acc);
        n_checks++;
        if (bus.cdb_valid !== 3'b001 || lane(0).tag !== 5'd4 || bus.buf_count !== 4'd0)
            $display("FAIL burst_second: got valid=%b tag=%0d count=%0d expected valid=001 tag=4 count=0",
                     bus.cdb_valid, lane(0).tag, bus.buf_count);
        else n_pass++;
        run_cycle(acc);
        n_checks++;
        if (bus.cdb_valid !== 3'b000)
            $display("FAIL burst_idle: got valid=%b expected 000", bus.cdb_valid);
        else n_pass++;
    endtask

    task automatic test_back_pressure();
        logic [NUM_FU-1:0] acc;
        int exp_count;
        for (int i = 0; i < NUM_FU; i++) fresh_fu(i);
        bus.fu_valid = 4'b1111;
        for (int c = 1; c <= 12; c++) begin
            run_cycle(acc);
            exp_count = (c < BUF_DEPTH) ? c : BUF_DEPTH;
            n_checks++;
            if (bus.buf_count !== CNTW'(exp_count))
                $display("FAIL bp_count_c%0d: got %0d expected %0d", c, bus.buf_count, exp_count);
            else n_pass++;
            if (c >= BUF_DEPTH) begin
                n_checks++;
                if (bus.fu_ready !== 4'b0111)
                    $display("FAIL bp_ready_c%0d: got %b expected %b", c, bus.fu_ready, 4'b0111);
                else n_pass++;
            end
            refill(acc);
        end
        drain();
    endtask

    task automatic test_squash();
        logic [NUM_FU-1:0] acc;
        for (int i = 0; i < NUM_FU; i++) fresh_fu(i);
        bus.fu_valid = 4'b1111;
        repeat (5) begin
            run_cycle(acc);
            refill(acc);
        end
        n_checks++;
        if (bus.buf_count !== 4'd5)
            $display("FAIL squash_prefill: got %0d expected %0d", bus.buf_count, 5);
        else n_pass++;
        bus.fu_valid = 4'b0011;
        squash_flag  = 1'b1;
        #1;
        n_checks++;
        if (bus.fu_ready !== 4'b0000)
            $display("FAIL squash_ready: got %b expected %b", bus.fu_ready, 4'b0000);
        else n_pass++;
        run_cycle(acc);
        n_checks++;
        if (bus.cdb_valid !== 3'b000 || bus.buf_count !== 4'd0)
            $display("FAIL squash_flush: got valid=%b count=%0d expected valid=000 count=0",
                     bus.cdb_valid, bus.buf_count);
        else n_pass++;
        squash_flag  = 1'b0;
        bus.fu_valid = '0;
        repeat (2) begin
            run_cycle(acc);
            n_checks++;
            if (bus.cdb_valid !== 3'b000)
                $display("FAIL squash_dropped: got valid=%b expected 000", bus.cdb_valid);
            else n_pass++;
        end
    endtask

    task automatic test_wrap_reset();
        logic [NUM_FU-1:0] acc;
        for (int i = 0; i < NUM_FU; i++) fresh_fu(i);
        bus.fu_valid = 4'b1111;
        for (int c = 0; c < 40; c++) begin
            run_cycle(acc);
            refill(acc);
        end
        for (int c = 0; c < 40; c++) begin
            run_cycle(acc);
            refill(acc);
            bus.fu_valid = (bus.fu_valid & ~acc) | NUM_FU'($urandom | $urandom);
        end
        drain();
        for (int i = 0; i < NUM_FU; i++) fresh_fu(i);
        bus.fu_valid = 4'b1111;
        repeat (6) begin
            run_cycle(acc);
            refill(acc);
        end
        n_checks++;
        if (bus.buf_count !== 4'd6)
            $display("FAIL wrap_prefill: got %0d expected %0d", bus.buf_count, 6);
        else n_pass++;
        reset = 1'b0;
        run_cycle(acc);
        n_checks++;
        if (bus.cdb_valid !== 3'b000 || bus.buf_count !== 4'd0)
            $display("FAIL midreset_state: got valid=%b count=%0d expected valid=000 count=0",
                     bus.cdb_valid, bus.buf_count);
        else n_pass++;
        reset        = 1'b1;
        bus.fu_valid = '0;
        run_cycle(acc);
        n_checks++;
        if (bus.cdb_valid !== 3'b000 || bus.buf_count !== 4'd0)
            $display("FAIL midreset_after: got valid=%b count=%0d expected valid=000 count=0",
                     bus.cdb_valid, bus.buf_count);
        else n_pass++;
    endtask

    initial begin
        bus.fu_valid       = '0;
        bus.fu_tag         = '0;
        bus.fu_value       = '0;
        bus.fu_take_branch = '0;
        bus.fu_npc         = '0;
        test_reset();
        test_single();
        test_burst();
        test_back_pressure();
        test_squash();
        test_wrap_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end
endmodule
